// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Each slot starts with an all-dark dead gap and then lights one digit. New
// values are held in a pending register and only become visible at a frame
// wrap, so a displayed frame never mixes old and new digits.
module seven_segment_scanner #(
    parameter int DIGITS        = 4,
    parameter int PRESCALE      = 50000,
    parameter int DEAD          = 500,
    parameter bit EN_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  suppress_lz,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  blank,
    output logic                  frame_tick
);

    localparam int            CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int            IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic {PH_DEAD, PH_ON} phase_t;

    phase_t                  phase_q, phase_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DIGITS-1:0][3:0]  pending_q, active_q;
    logic [DIGITS-1:0]       mask_q;
    logic                    sup_q;
    logic                    slot_end, wrap;
    logic [DIGITS:0]         upper_zero;
    logic [DIGITS-1:0]       lz_zero;
    logic                    dark;
    logic [DIGITS-1:0]       en_hot;

    assign slot_end = (cnt_q == CNT_LAST);
    assign wrap     = slot_end && (idx_q == IDX_LAST);

    // Prescaler / digit index advance and slot phase for the next cycle
    always_comb begin
        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        if (slot_end)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        phase_d = (cnt_d < CNT_DEAD) ? PH_DEAD : PH_ON;
    end

    // State registers; blank_mask and suppress_lz are registered so outputs
    // never depend combinationally on inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            phase_q    <= PH_DEAD;
            pending_q  <= '0;
            active_q   <= '0;
            mask_q     <= '0;
            sup_q      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            mask_q     <= blank_mask;
            sup_q      <= suppress_lz;
            frame_tick <= wrap;
            if (load)
                pending_q <= value;
            // A load on the wrap cycle bypasses pending so it shows at once
            if (wrap)
                active_q <= load ? value : pending_q;
        end
    end

    // upper_zero[k]: digits k..DIGITS-1 of the active value are all zero
    assign upper_zero[DIGITS] = 1'b1;
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
        assign upper_zero[k] = upper_zero[k+1] && (active_q[k] == 4'h0);
    end
    assign lz_zero = upper_zero[DIGITS-1:0];

    // Dark-slot decision and one-hot digit enable, all from registered state
    always_comb begin
        dark = (phase_q == PH_DEAD) || mask_q[idx_q]
            || (sup_q && (idx_q != '0) && lz_zero[idx_q]);
        en_hot = '0;
        for (int k = 0; k < DIGITS; k++)
            en_hot[k] = !dark && (idx_q == IW'(k));
    end

    assign nibble   = active_q[idx_q];
    assign blank    = dark;
    assign digit_en = EN_ACTIVE_LOW ? ~en_hot : en_hot;

endmodule
